// File: rtl/reset_source_sched.sv
`timescale 1ns/1ps
// Reset-source scheduler: collects edge-triggered reset requests, runs one staged
// core/padding/watchdog/holdoff sequence per grant and records cause statistics.
module reset_source_sched #(
  parameter int                 NUM_SRC         = 4,
  parameter int                 CORE_RST_CYCLES = 60,
  parameter int                 PADDING_CYCLES  = 5,
  parameter int                 WDG_RST_CYCLES  = 1,
  parameter int                 HOLDOFF_CYCLES  = 16,
  parameter logic [NUM_SRC-1:0] WDG_RST_MASK    = NUM_SRC'(4'b0001),
  parameter int                 CNT_W           = 8,
  localparam int                IDX_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               sys_res,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               cause_clr,
  output logic               core_res_n,
  output logic               wdg_res_n,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause,
  output logic [IDX_W-1:0]   last_src,
  output logic [CNT_W-1:0]   rst_count
);

  localparam int MAX_A   = (CORE_RST_CYCLES > PADDING_CYCLES) ? CORE_RST_CYCLES : PADDING_CYCLES;
  localparam int MAX_B   = (WDG_RST_CYCLES > HOLDOFF_CYCLES) ? WDG_RST_CYCLES : HOLDOFF_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] CORE_LOAD = TMR_W'(CORE_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] PAD_LOAD  = TMR_W'(PADDING_CYCLES - 1);
  localparam logic [TMR_W-1:0] WDG_LOAD  = TMR_W'(WDG_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORE_RST,
    ST_PADDING,
    ST_WDG_RST,
    ST_HOLDOFF
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [NUM_SRC-1:0] req_q, req_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] grp_q, grp_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [IDX_W-1:0]   last_src_q, last_src_d;
  logic [CNT_W-1:0]   rst_count_q, rst_count_d;
  logic               core_res_n_q, core_res_n_d;
  logic               wdg_res_n_q, wdg_res_n_d;
  logic               busy_q, busy_d;

  logic [NUM_SRC-1:0] src_hit;
  logic               tmr_zero;

  assign src_hit  = src_req & ~req_q & src_en;
  assign tmr_zero = (tmr_q == '0);

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // NOTE: every variable gets its default first, so no branch can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    tmr_d       = tmr_q;
    req_d       = src_req;
    pending_d   = pending_q;
    grp_d       = grp_q;
    cause_d     = cause_clr ? '0 : cause_q;
    last_src_d  = last_src_q;
    rst_count_d = rst_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          state_d    = ST_CORE_RST;
          tmr_d      = CORE_LOAD;
          grp_d      = pending_q;
          // An edge arriving in the grant cycle is kept for the next sequence.
          pending_d  = src_hit;
          cause_d    = cause_d | pending_q;
          last_src_d = lowest_idx(pending_q);
          if (rst_count_q != '1) rst_count_d = rst_count_q + CNT_W'(1);
        end else begin
          pending_d = pending_q | src_hit;
        end
      end
      ST_CORE_RST: begin
        if (tmr_zero) begin
          state_d = ST_PADDING;
          tmr_d   = PAD_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_PADDING: begin
        if (tmr_zero) begin
          if ((grp_q & WDG_RST_MASK) != '0) begin
            state_d = ST_WDG_RST;
            tmr_d   = WDG_LOAD;
          end else begin
            state_d = ST_HOLDOFF;
            tmr_d   = HOLD_LOAD;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WDG_RST: begin
        if (tmr_zero) begin
          state_d = ST_HOLDOFF;
          tmr_d   = HOLD_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_HOLDOFF: begin
        pending_d = pending_q | src_hit;
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs decode the next state so they leave the flops glitch-free.
    core_res_n_d = (state_d != ST_CORE_RST);
    wdg_res_n_d  = (state_d != ST_WDG_RST);
    busy_d       = (state_d != ST_IDLE);
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or posedge sys_res) begin
    if (sys_res) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      req_q        <= '1;
      pending_q    <= '0;
      grp_q        <= '0;
      cause_q      <= '0;
      last_src_q   <= '0;
      rst_count_q  <= '0;
      core_res_n_q <= 1'b1;
      wdg_res_n_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      req_q        <= req_d;
      pending_q    <= pending_d;
      grp_q        <= grp_d;
      cause_q      <= cause_d;
      last_src_q   <= last_src_d;
      rst_count_q  <= rst_count_d;
      core_res_n_q <= core_res_n_d;
      wdg_res_n_q  <= wdg_res_n_d;
      busy_q       <= busy_d;
    end
  end

  assign core_res_n = core_res_n_q;
  assign wdg_res_n  = wdg_res_n_q;
  assign busy       = busy_q;
  assign cause      = cause_q;
  assign last_src   = last_src_q;
  assign rst_count  = rst_count_q;

endmodule

// File: tb/tb_reset_source_sched.sv
`timescale 1ns/1ps
// Bench for reset_source_sched: a timing-arithmetic reference model predicts each
// grant; a monitor pops those predictions whenever a core reset sequence starts.
module tb_reset_source_sched;

  localparam int         N    = 4;
  localparam int         C    = 60;
  localparam int         P    = 5;
  localparam int         W    = 1;
  localparam int         H    = 16;
  localparam int         CW   = 8;
  localparam logic [3:0] MASK = 4'b0001;

  logic         clk;
  logic         sys_res;
  logic [N-1:0] src_req;
  logic [N-1:0] src_en;
  logic         cause_clr;
  logic         core_res_n;
  logic         wdg_res_n;
  logic         busy;
  logic [N-1:0] cause;
  logic [1:0]   last_src;
  logic [CW-1:0] rst_count;

  reset_source_sched #(
    .NUM_SRC(N), .CORE_RST_CYCLES(C), .PADDING_CYCLES(P), .WDG_RST_CYCLES(W),
    .HOLDOFF_CYCLES(H), .WDG_RST_MASK(MASK), .CNT_W(CW)
  ) dut (
    .clk(clk), .sys_res(sys_res), .src_req(src_req), .src_en(src_en),
    .cause_clr(cause_clr), .core_res_n(core_res_n), .wdg_res_n(wdg_res_n),
    .busy(busy), .cause(cause), .last_src(last_src), .rst_count(rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] cause;
    int           last;
    int           count;
    bit           wdg;
  } rec_t;

  rec_t exp_q[$];

  // Reference model: tracks how many busy cycles remain after each grant.
  logic [N-1:0] m_prev, m_pend, m_cause, m_hits;
  int           m_cnt, m_left;
  bit           m_idle, m_open;
  rec_t         m_rec;

  function automatic int low_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge sys_res) begin
    if (sys_res) begin
      m_prev  = '1;
      m_pend  = '0;
      m_cause = '0;
      m_cnt   = 0;
      m_left  = 0;
      exp_q.delete();
    end else begin
      m_hits = src_req & ~m_prev & src_en;
      m_prev = src_req;
      m_idle = (m_left == 0);
      m_open = m_idle || (m_left <= H);
      if (cause_clr) m_cause = '0;
      if (m_idle && m_pend != '0) begin
        m_cause     = m_cause | m_pend;
        m_cnt       = (m_cnt < (2**CW) - 1) ? m_cnt + 1 : m_cnt;
        m_rec.cause = m_cause;
        m_rec.last  = low_idx(m_pend);
        m_rec.count = m_cnt;
        m_rec.wdg   = |(m_pend & MASK);
        exp_q.push_back(m_rec);
        m_left = C + P + (m_rec.wdg ? W : 0) + H;
        m_pend = m_hits;
      end else begin
        if (m_open) m_pend = m_pend | m_hits;
        if (m_left > 0) m_left--;
      end
    end
  end

  // Monitor: a falling core_res_n starts a sequence; its shape is measured until busy drops.
  bit   mon_in_seq;
  logic mon_prev_core;
  int   busy_len, core_low, wdg_low, wdg_start;
  rec_t cur;

  always @(negedge clk) begin
    if (sys_res) begin
      mon_in_seq    = 1'b0;
      mon_prev_core = 1'b1;
    end else begin
      if (!mon_in_seq && mon_prev_core === 1'b1 && core_res_n === 1'b0) begin
        check("seq_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("cause_at_grant", cause, cur.cause);
          check("last_src_at_grant", last_src, cur.last);
          check("rst_count_at_grant", rst_count, cur.count);
        end else begin
          cur.wdg = 1'b0;
        end
        mon_in_seq = 1'b1;
        busy_len   = 0;
        core_low   = 0;
        wdg_low    = 0;
        wdg_start  = 0;
      end
      if (mon_in_seq) begin
        if (busy === 1'b1) begin
          busy_len++;
          if (core_res_n === 1'b0) core_low++;
          if (wdg_res_n === 1'b0) begin
            wdg_low++;
            if (wdg_start == 0) wdg_start = busy_len;
          end
        end else begin
          check("busy_len", busy_len, C + P + (cur.wdg ? W : 0) + H);
          check("core_low_len", core_low, C);
          check("wdg_low_len", wdg_low, cur.wdg ? W : 0);
          check("wdg_start", wdg_start, cur.wdg ? C + P + 1 : 0);
          mon_in_seq = 1'b0;
        end
      end
      mon_prev_core = core_res_n;
    end
  end

  task automatic do_reset(input logic [N-1:0] hold_req);
    sys_res = 1'b1;
    src_req = hold_req;
    repeat (3) @(negedge clk);
    sys_res = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clk);
    src_req = src_req | m;
    @(negedge clk);
    src_req = src_req & ~m;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1);
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    while (q < 5 && n < 3000) begin
      @(negedge clk);
      n++;
      q = (busy === 1'b0) ? q + 1 : 0;
    end
    check(name, q >= 5, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sys_res   = 1'b1;
    src_req   = '0;
    src_en    = '1;
    cause_clr = 1'b0;
    repeat (3) @(negedge clk);
    sys_res = 1'b0;
    @(negedge clk);

    check("rst_core_res_n", core_res_n, 1);
    check("rst_wdg_res_n", wdg_res_n, 1);
    check("rst_busy", busy, 0);
    check("rst_cause", cause, 0);
    check("rst_last_src", last_src, 0);
    check("rst_count", rst_count, 0);

    // Single request with latency check
    @(negedge clk);
    src_req = 4'b0100;
    @(negedge clk);
    check("latency_edge_k", core_res_n, 1);
    src_req = '0;
    @(negedge clk);
    check("latency_edge_k1", core_res_n, 0);
    wait_quiet("single_quiet");
    check("single_cause", cause, 4'b0100);
    check("single_last", last_src, 2);
    check("single_count", rst_count, 1);

    // Watchdog source
    pulse(4'b0001);
    wait_busy("wdg_busy");
    wait_quiet("wdg_quiet");
    check("wdg_cause", cause, 4'b0101);
    check("wdg_count", rst_count, 2);

    // Simultaneous requests
    do_reset('0);
    pulse(4'b1010);
    wait_busy("simul_busy");
    wait_quiet("simul_quiet");
    check("simul_cause", cause, 4'b1010);
    check("simul_last", last_src, 1);
    check("simul_count", rst_count, 1);

    // Edge during CORE_RST is dropped, edge during HOLDOFF queues a second run
    do_reset('0);
    pulse(4'b0100);
    wait_busy("mid_busy");
    repeat (10) @(negedge clk);
    pulse(4'b0100);
    repeat (58) @(negedge clk);
    pulse(4'b0100);
    wait_quiet("mid_quiet");
    check("mid_count", rst_count, 2);

    // Request held through reset release, then a disabled source
    do_reset(4'b0010);
    repeat (100) @(negedge clk);
    check("held_busy", busy, 0);
    check("held_count", rst_count, 0);
    src_req = '0;
    src_en  = 4'b1101;
    pulse(4'b0010);
    repeat (100) @(negedge clk);
    check("disabled_busy", busy, 0);
    check("disabled_count", rst_count, 0);
    // Enable dropped after capture keeps the pending bit
    src_en  = '1;
    @(negedge clk);
    src_req = 4'b0010;
    @(negedge clk);
    src_en  = 4'b1101;
    src_req = '0;
    wait_busy("late_dis_busy");
    src_en  = '1;
    wait_quiet("late_dis_quiet");
    check("late_dis_count", rst_count, 1);

    // Asynchronous system reset in the middle of CORE_RST
    pulse(4'b0100);
    wait_busy("async_busy");
    repeat (20) @(negedge clk);
    #2 sys_res = 1'b1;
    #1;
    check("async_core_res_n", core_res_n, 1);
    check("async_wdg_res_n", wdg_res_n, 1);
    check("async_cause", cause, 0);
    check("async_count", rst_count, 0);
    repeat (3) @(negedge clk);
    sys_res = 1'b0;
    @(negedge clk);

    // Counter saturation
    for (int i = 0; i < 256; i++) begin
      pulse(4'b1000);
      wait_quiet("sat_quiet");
    end
    check("sat_count", rst_count, 255);

    // cause_clr in the grant cycle keeps only the new grant
    pulse(4'b0100);
    wait_quiet("clr_pre_quiet");
    check("clr_pre_cause", cause, 4'b1100);
    @(negedge clk);
    src_req = 4'b1000;
    @(negedge clk);
    src_req   = '0;
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    wait_quiet("clr_quiet");
    check("clr_cause", cause, 4'b1000);

    // Randomized traffic
    do_reset('0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      src_req   = src_req ^ N'((($urandom_range(0, 15) == 0) ? 1 : 0) << $urandom_range(0, N - 1));
      cause_clr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 49) == 0) src_en = N'($urandom | $urandom);
    end
    @(negedge clk);
    src_req   = '0;
    cause_clr = 1'b0;
    src_en    = '1;
    wait_quiet("rand_quiet1");
    wait_quiet("rand_quiet2");

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_source_sched.md
Name: reset_source_sched

Overview:
- Collects reset requests from up to NUM_SRC sources: watchdog timeout, software reset request, debug reset and external button.
- Arbitrates between them and runs one staged reset sequence: core reset, padding, optional watchdog reset, then holdoff.
- Keeps a sticky reset-cause record, the last granted source and a saturating reset counter for software to read after boot.
- Sits in the always-on domain. Its own reset is the system reset only and is never driven by core_res_n or wdg_res_n.

Parameters:
- NUM_SRC, 4: number of request sources; index 0 has the highest priority.
- CORE_RST_CYCLES, 60: cycles core_res_n is held low; must be at least 1.
- PADDING_CYCLES, 5: cycles with no reset asserted between the core and watchdog phases; must be at least 1.
- WDG_RST_CYCLES, 1: cycles wdg_res_n is held low; must be at least 1.
- HOLDOFF_CYCLES, 16: quiet cycles after a sequence before the next grant; must be at least 1.
- WDG_RST_MASK, 4'b0001: a source whose bit is set also triggers the watchdog reset phase.
- CNT_W, 8: width of rst_count.

Ports:
- clk  in  1  system clock
- sys_res  in  1  system reset; asynchronous, active-high
- src_req  in  NUM_SRC  reset requests; a rising edge of a bit is a request
- src_en  in  NUM_SRC  per-source enable; an edge on a disabled source is discarded
- cause_clr  in  1  single-cycle pulse that clears cause
- core_res_n  out  1  active-low core reset; AND-ed externally with the system reset
- wdg_res_n  out  1  active-low watchdog reset; AND-ed externally with the system reset
- busy  out  1  high in every state except IDLE
- cause  out  NUM_SRC  sticky OR of all granted source sets
- last_src  out  $clog2(NUM_SRC)  lowest index in the most recent granted set
- rst_count  out  CNT_W  number of grants, saturating

Behaviour:
- Reset values (async on sys_res):
  - state = IDLE, pending = 0, counter = 0.
  - req_q = all ones, so a source held high through reset does not fire.
  - core_res_n = 1, wdg_res_n = 1, busy = 0, cause = 0, last_src = 0, rst_count = 0.
- Edge detect: edge[i] = src_req[i] & ~req_q[i]; req_q <= src_req every cycle.
- Pending capture:
  - pending[i] is set at the clock edge after edge[i] & src_en[i], in IDLE or HOLDOFF only.
  - Edges in CORE_RST, PADDING or WDG_RST are discarded.
- State machine: IDLE, CORE_RST, PADDING, WDG_RST, HOLDOFF. A single down-counter is loaded on state entry; a state exits when the counter reaches 0.
  - IDLE, pending != 0: grant.
    - grp <= pending; pending <= 0; go to CORE_RST.
    - cause <= cause | pending; last_src <= lowest set index; rst_count increments, saturating at all ones.
  - CORE_RST: lasts exactly CORE_RST_CYCLES cycles with core_res_n = 0, then go to PADDING.
  - PADDING: lasts PADDING_CYCLES cycles, then:
    - go to WDG_RST if (grp & WDG_RST_MASK) != 0;
    - otherwise go to HOLDOFF.
  - WDG_RST: lasts WDG_RST_CYCLES cycles with wdg_res_n = 0, then go to HOLDOFF.
  - HOLDOFF: lasts HOLDOFF_CYCLES cycles, then go to IDLE. Pending captured during HOLDOFF is granted on the first IDLE cycle.
- Outputs: core_res_n, wdg_res_n and busy are registered state decodes and glitch-free.
- Latency: if the first sampled-high edge of src_req is at clock edge k, then pending is set after edge k and core_res_n falls after edge k+1.
- Simultaneous requests:
  - All requests pending at grant are merged into one sequence; all of their bits go into cause.
  - last_src is the lowest granted index.
  - The watchdog phase runs if any granted bit is in WDG_RST_MASK.
- cause_clr in the same cycle as a grant: cause <= pending (the grant wins; old bits are cleared). cause_clr while busy clears only the old bits.
- src_en deasserted after capture does not cancel a pending bit.
- sys_res mid-sequence: both reset outputs return to 1 immediately; all state and statistics are lost.

Test Plan:
- Single request: after sys_res, pulse src_req[2] with src_en = 4'hF.
  - core_res_n falls 2 cycles after the sampled edge and stays low for exactly 60 cycles.
  - PADDING lasts 5 cycles; wdg_res_n never falls; busy is high for 60+5+16 = 81 cycles.
  - cause = 4'b0100, last_src = 2, rst_count = 1.
- Watchdog source: pulse src_req[0].
  - wdg_res_n is low for exactly 1 cycle, starting 60+5 cycles after core_res_n falls.
  - busy is high for 82 cycles.
- Simultaneous requests: src_req[1] and src_req[3] rise in the same cycle.
  - Exactly one sequence runs; cause = 4'b1010, last_src = 1, rst_count = 1.
- Requests during a sequence:
  - An edge on src_req[2] during CORE_RST is ignored.
  - An edge during HOLDOFF runs a second sequence immediately after HOLDOFF; rst_count = 2.
- Masking and reset:
  - Hold src_req[1] high through sys_res release: no sequence runs.
  - An edge with src_en[1] = 0 is ignored.
  - Assert sys_res mid-CORE_RST: core_res_n = 1 asynchronously; cause and rst_count read 0.
- Counter saturation and clear:
  - Run 256 grants with CNT_W = 8: rst_count saturates at 255.
  - cause_clr coinciding with a grant of src_req[3]: cause = 4'b1000.
